lives_manager: RTL and testbench

- Upstream neighbour of the game-state controller.
- Owns the player's remaining lives, the death/explosion sequence and the post-respawn invulnerability window.
- Consumes raw player-collision pulses from the collision logic. Produces game_over, explode and the lives count, which feed the game-state controller and the sprite/HUD renderers.
- Advances once per frame.

---
 rtl/galaxian_pkg.sv | 26 ++
 rtl/frame_timer.sv | 28 ++
 rtl/lives_manager.sv | 139 +++++++++++++
 tb/tb_lives_manager.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/galaxian_pkg.sv
// Shared types and defaults for the Galaxian player-lifecycle logic.
package galaxian_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIVE,
        EXPLODING,
        RESPAWN,
        DEAD
    } life_state_t;

    localparam int START_LIVES_D   = 3;
    localparam int LIVES_W_D       = 2;
    localparam int DEATH_FRAMES_D  = 60;
    localparam int INVULN_FRAMES_D = 120;

    // Width needed to hold the larger of two frame counts minus one, never below 1 bit.
    function automatic int timer_width(input int a, input int b);
        int biggest;
        int w;
        biggest = (a > b) ? a : b;
        w = $clog2(biggest);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; done is high whenever the count has reached zero.
module frame_timer #(
    parameter int WIDTH = 7
) (
    input  logic             frame_clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load wins over counting; the count parks at zero rather than wrapping.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lives_manager.sv
// Player lives, death explosion and post-respawn invulnerability, advanced once per frame.
module lives_manager
    import galaxian_pkg::*;
#(
    parameter int START_LIVES   = START_LIVES_D,
    parameter int LIVES_W       = LIVES_W_D,
    parameter int DEATH_FRAMES  = DEATH_FRAMES_D,
    parameter int INVULN_FRAMES = INVULN_FRAMES_D
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               level,
    input  logic               collision,
    output logic [LIVES_W-1:0] lives,
    output logic               explode,
    output logic               player_active,
    output logic               invulnerable,
    output logic               game_over
);

    localparam int TIMER_W = timer_width(DEATH_FRAMES, INVULN_FRAMES);
    localparam logic [TIMER_W-1:0] DEATH_LOAD  = TIMER_W'(DEATH_FRAMES - 1);
    localparam logic [TIMER_W-1:0] INVULN_LOAD = TIMER_W'(INVULN_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);

    life_state_t        state;
    life_state_t        state_next;
    logic [LIVES_W-1:0] lives_next;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_en;
    logic               timer_done;
    logic               explode_next;
    logic               active_next;
    logic               invuln_next;
    logic               over_next;

    frame_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .load      (timer_load),
        .load_value(timer_value),
        .enable    (timer_en),
        .done      (timer_done)
    );

    // Flags are decoded from the next state and registered alongside it, so they never glitch.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            lives         <= LIVES_INIT;
            explode       <= 1'b0;
            player_active <= 1'b0;
            invulnerable  <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_next;
            lives         <= lives_next;
            explode       <= explode_next;
            player_active <= active_next;
            invulnerable  <= invuln_next;
            game_over     <= over_next;
        end
    end

    always_comb begin
        state_next  = state;
        lives_next  = lives;
        timer_load  = 1'b0;
        timer_value = '0;
        timer_en    = 1'b0;
        case (state)
            IDLE: begin
                if (level) begin
                    state_next = ALIVE;
                    lives_next = LIVES_INIT;
                end
            end
            ALIVE: begin
                if (!level) begin
                    state_next = IDLE;
                    lives_next = LIVES_INIT;
                    timer_load = 1'b1;
                end else if (collision) begin
                    state_next  = EXPLODING;
                    lives_next  = lives - LIVES_W'(1);
                    timer_load  = 1'b1;
                    timer_value = DEATH_LOAD;
                end
            end
            EXPLODING: begin
                if (!level) begin
                    state_next = IDLE;
                    lives_next = LIVES_INIT;
                    timer_load = 1'b1;
                end else if (timer_done) begin
                    if (lives == '0) begin
                        state_next = DEAD;
                    end else begin
                        state_next  = RESPAWN;
                        timer_load  = 1'b1;
                        timer_value = INVULN_LOAD;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            RESPAWN: begin
                if (!level) begin
                    state_next = IDLE;
                    lives_next = LIVES_INIT;
                    timer_load = 1'b1;
                end else if (timer_done) begin
                    state_next = ALIVE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            DEAD: begin
                lives_next = '0;
            end
            default: begin
                state_next = IDLE;
                lives_next = LIVES_INIT;
                timer_load = 1'b1;
            end
        endcase
    end

    always_comb begin
        explode_next = (state_next == EXPLODING);
        active_next  = (state_next == ALIVE) || (state_next == RESPAWN);
        invuln_next  = (state_next == RESPAWN);
        over_next    = (state_next == DEAD);
    end

endmodule

// File: tb/tb_lives_manager.sv
// Randomised and directed bench for lives_manager against a frame-count model of the player lifecycle.
module tb_lives_manager;

    localparam int START  = 3;
    localparam int DEATH  = 60;
    localparam int INVULN = 120;

    logic       frame_clk;
    logic       Reset_n;
    logic       level;
    logic       collision;
    logic [1:0] lives;
    logic       explode;
    logic       player_active;
    logic       invulnerable;
    logic       game_over;

    int errors = 0;
    int checks = 0;
    bit cmpOn  = 1'b0;

    int mdlLives;
    int mdlBoom;
    int mdlShield;
    bit mdlPlaying;
    bit mdlOver;

    lives_manager #(
        .START_LIVES  (START),
        .LIVES_W      (2),
        .DEATH_FRAMES (DEATH),
        .INVULN_FRAMES(INVULN)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .level        (level),
        .collision    (collision),
        .lives        (lives),
        .explode      (explode),
        .player_active(player_active),
        .invulnerable (invulnerable),
        .game_over    (game_over)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    // The model thinks in frames left of explosion and of shield, not in controller states.
    always @(posedge frame_clk or negedge Reset_n) begin
        int  nl, nb, ns;
        bit  np, no;
        if (!Reset_n) begin
            mdlLives   <= START;
            mdlBoom    <= 0;
            mdlShield  <= 0;
            mdlPlaying <= 1'b0;
            mdlOver    <= 1'b0;
        end else begin
            nl = mdlLives; nb = mdlBoom; ns = mdlShield; np = mdlPlaying; no = mdlOver;
            if (no) begin
                nl = 0;
            end else if (!np) begin
                if (level) begin
                    np = 1'b1;
                    nl = START;
                end
            end else if (!level) begin
                np = 1'b0; nl = START; nb = 0; ns = 0;
            end else if (nb > 0) begin
                nb = nb - 1;
                if (nb == 0) begin
                    if (nl == 0) begin
                        no = 1'b1;
                        np = 1'b0;
                    end else begin
                        ns = INVULN;
                    end
                end
            end else if (ns > 0) begin
                ns = ns - 1;
            end else if (collision) begin
                nl = nl - 1;
                nb = DEATH;
            end
            mdlLives   <= nl;
            mdlBoom    <= nb;
            mdlShield  <= ns;
            mdlPlaying <= np;
            mdlOver    <= no;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge frame_clk) begin
        if (cmpOn) begin
            checkOutput("model_lives", 32'(lives), 32'(mdlLives));
            checkOutput("model_explode", 32'(explode), 32'(mdlBoom > 0));
            checkOutput("model_invulnerable", 32'(invulnerable), 32'(mdlShield > 0));
            checkOutput("model_player_active", 32'(player_active),
                        32'(mdlPlaying && !mdlOver && mdlBoom == 0));
            checkOutput("model_game_over", 32'(game_over), 32'(mdlOver));
        end
    end

    task automatic applyStimulus(input logic lv, input logic col);
        level     = lv;
        collision = col;
        @(negedge frame_clk);
    endtask

    function automatic logic pick(input int which);
        return (which == 0) ? explode : invulnerable;
    endfunction

    // colMode: 0 quiet, 1 random pulses, 2 held high.
    task automatic countFrames(input int which, input int limit, input int colMode, output int n);
        logic col;
        n = 0;
        while (pick(which) === 1'b1 && n < limit) begin
            n++;
            col = (colMode == 2) ? 1'b1 : (colMode == 1) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            applyStimulus(1'b1, col);
        end
    endtask

    initial begin
        int  n;
        bit  lvl;
        Reset_n   = 1'b0;
        level     = 1'b0;
        collision = 1'b0;
        repeat (2) @(negedge frame_clk);
        checkOutput("reset_lives", 32'(lives), 32'd3);
        checkOutput("reset_flags", 32'({explode, player_active, invulnerable, game_over}), 32'd0);
        Reset_n = 1'b1;
        cmpOn   = 1'b1;

        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("idle_lives", 32'(lives), 32'd3);
        checkOutput("idle_inactive", 32'(player_active), 32'd0);

        applyStimulus(1'b1, 1'b0);
        checkOutput("alive_active", 32'(player_active), 32'd1);
        repeat (4) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("hit1_explode", 32'(explode), 32'd1);
        checkOutput("hit1_lives", 32'(lives), 32'd2);
        checkOutput("hit1_inactive", 32'(player_active), 32'd0);
        countFrames(0, 200, 1, n);
        checkOutput("explode_frames", 32'(n), 32'd60);
        countFrames(1, 300, 1, n);
        checkOutput("invuln_frames", 32'(n), 32'd120);
        applyStimulus(1'b1, 1'b0);
        checkOutput("back_alive", 32'(player_active), 32'd1);
        checkOutput("ignored_hits_lives", 32'(lives), 32'd2);

        applyStimulus(1'b1, 1'b1);
        countFrames(0, 200, 0, n);
        countFrames(1, 300, 1, n);
        checkOutput("hit2_lives", 32'(lives), 32'd1);
        applyStimulus(1'b1, 1'b1);
        countFrames(0, 200, 0, n);
        checkOutput("over_flag", 32'(game_over), 32'd1);
        checkOutput("over_lives", 32'(lives), 32'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checkOutput("over_sticky", 32'(game_over), 32'd1);

        Reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        Reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("first_frame_hit", 32'(lives), 32'd2);
        countFrames(0, 200, 2, n);
        countFrames(1, 300, 2, n);
        applyStimulus(1'b1, 1'b1);
        checkOutput("held_hit_explode", 32'(explode), 32'd1);
        checkOutput("held_hit_lives", 32'(lives), 32'd1);
        repeat (10) applyStimulus(1'b1, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("async_explode", 32'(explode), 32'd0);
        checkOutput("async_lives", 32'(lives), 32'd3);
        checkOutput("async_active", 32'(player_active), 32'd0);
        #1 Reset_n = 1'b1;
        @(negedge frame_clk);

        applyStimulus(1'b1, 1'b1);
        countFrames(0, 200, 0, n);
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("respawn_shield", 32'(invulnerable), 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("drop_shield", 32'(invulnerable), 32'd0);
        checkOutput("drop_lives", 32'(lives), 32'd3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("relevel_active", 32'(player_active), 32'd1);
        checkOutput("relevel_lives", 32'(lives), 32'd3);

        lvl = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #1 Reset_n = 1'b0;
                #2 Reset_n = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) lvl = ~lvl;
            applyStimulus(lvl, 1'($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
